// File: rtl/branch_resolver_if.sv
// Signal bundle between the fetch/execute pipeline and the branch resolver.
// The pipeline drives the master side; the resolver is the slave.
interface branch_resolver_if;
  logic        br_det;
  logic        ex_valid;
  logic [1:0]  ex_type;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        fetch_hold;
  logic        pc_sel;
  logic        flush;
  logic [31:0] pc_target;
  logic [31:0] link_addr;
  logic        resolve_err;
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;

  modport master (
    output br_det, ex_valid, ex_type, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm,
    input  fetch_hold, pc_sel, flush, pc_target, link_addr, resolve_err, taken_cnt,
           nottaken_cnt
  );

  modport slave (
    input  br_det, ex_valid, ex_type, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm,
    output fetch_hold, pc_sel, flush, pc_target, link_addr, resolve_err, taken_cnt,
           nottaken_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// Holds fetch while a detected branch awaits its EX-stage resolution, then issues a
// one-cycle redirect/flush for taken branches and keeps resolution statistics.
module branch_resolver #(
  parameter int unsigned WAIT_MAX = 4,
  parameter int unsigned CntWidth = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolver_if.slave bus
);

  localparam int unsigned WaitW    = $clog2(WAIT_MAX + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX);
  // Statistics saturate at the all-ones value of a CntWidth-bit counter.
  localparam logic [15:0] CntMax   = 16'((32'd1 << CntWidth) - 32'd1);

  typedef enum logic [1:0] {StIdle, StPend, StRedir} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [31:0]      pc_target_q, pc_target_d;
  logic [31:0]      link_addr_q, link_addr_d;
  logic             err_q, err_d;
  logic [15:0]      taken_cnt_q, taken_cnt_d;
  logic [15:0]      nottaken_cnt_q, nottaken_cnt_d;

  logic             taken;
  logic             illegal;
  logic [31:0]      target;
  logic [31:0]      jalr_sum;
  logic [WaitW-1:0] wait_inc;

  assign jalr_sum = bus.ex_rs1 + bus.ex_imm;
  assign wait_inc = wait_q + WaitW'(1);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    target  = bus.ex_pc + bus.ex_imm;
    case (bus.ex_type)
      2'b00: begin
        case (bus.ex_funct3)
          3'b000:  taken = (bus.ex_rs1 == bus.ex_rs2);
          3'b001:  taken = (bus.ex_rs1 != bus.ex_rs2);
          3'b100:  taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
          3'b101:  taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
          3'b110:  taken = (bus.ex_rs1 <  bus.ex_rs2);
          3'b111:  taken = (bus.ex_rs1 >= bus.ex_rs2);
          default: illegal = 1'b1;
        endcase
      end
      2'b01:   taken = 1'b1;
      2'b10: begin
        taken  = 1'b1;
        target = {jalr_sum[31:1], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    pc_target_d    = pc_target_q;
    link_addr_d    = link_addr_q;
    err_d          = err_q;
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ex_valid) err_d = 1'b1;
        if (bus.br_det) begin
          state_d = StPend;
          wait_d  = '0;
        end
      end
      StPend: begin
        if (bus.ex_valid) begin
          link_addr_d = bus.ex_pc + 32'd4;
          if (illegal) err_d = 1'b1;
          if (taken) begin
            state_d     = StRedir;
            pc_target_d = target;
            if (taken_cnt_q != CntMax) taken_cnt_d = taken_cnt_q + 16'd1;
          end else begin
            state_d = StIdle;
            if (nottaken_cnt_q != CntMax) nottaken_cnt_d = nottaken_cnt_q + 16'd1;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WaitLast) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      StRedir: begin
        if (bus.ex_valid) err_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      wait_q         <= '0;
      pc_target_q    <= '0;
      link_addr_q    <= '0;
      err_q          <= 1'b0;
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      pc_target_q    <= pc_target_d;
      link_addr_q    <= link_addr_d;
      err_q          <= err_d;
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end

  assign bus.fetch_hold   = (state_q == StPend);
  assign bus.pc_sel       = (state_q == StRedir);
  assign bus.flush        = (state_q == StRedir);
  assign bus.pc_target    = pc_target_q;
  assign bus.link_addr    = link_addr_q;
  assign bus.resolve_err  = err_q;
  assign bus.taken_cnt    = taken_cnt_q;
  assign bus.nottaken_cnt = nottaken_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and randomized checks of branch_resolver with a scoreboard of expected
// post-resolution outputs; a narrow-counter instance exercises saturation.
module tb_branch_resolver;

  typedef struct {
    logic        pc_sel;
    logic [31:0] target;
    logic [31:0] link;
    logic [15:0] tc;
    logic [15:0] nc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  logic [31:0] m_target, m_link;
  logic [15:0] m_tc, m_nc;
  logic        m_err;
  logic [2:0]  legal_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  branch_resolver_if bus ();
  branch_resolver_if sat_bus ();

  branch_resolver #(.WAIT_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  branch_resolver #(.WAIT_MAX(4), .CntWidth(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_illegal(input logic [1:0] t, input logic [2:0] f);
    return (t == 2'b11) || (t == 2'b00 && (f == 3'b010 || f == 3'b011));
  endfunction

  function automatic logic model_taken(input logic [1:0] t, input logic [2:0] f,
                                       input logic [31:0] a, input logic [31:0] b);
    if (t == 2'b01 || t == 2'b10) return 1'b1;
    if (t != 2'b00) return 1'b0;
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_target = '0;
    m_link   = '0;
    m_tc     = '0;
    m_nc     = '0;
    m_err    = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.br_det   = 1'b0;
    bus.ex_valid = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_target"}, bus.pc_target, m_target);
    chk({tag, "_link"}, bus.link_addr, m_link);
    chk({tag, "_tcnt"}, {16'd0, bus.taken_cnt}, {16'd0, m_tc});
    chk({tag, "_ncnt"}, {16'd0, bus.nottaken_cnt}, {16'd0, m_nc});
    chk({tag, "_err"}, {31'd0, bus.resolve_err}, {31'd0, m_err});
  endtask

  // One full branch: detect, resolve next cycle, check outputs after the resolving edge.
  task automatic resolve(input string tag, input logic [1:0] t, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm);
    exp_t        e;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] sum;
    bus.br_det = 1'b1;
    step();
    chk({tag, "_hold"}, {31'd0, bus.fetch_hold}, 32'd1);
    bus.br_det    = 1'b0;
    bus.ex_valid  = 1'b1;
    bus.ex_type   = t;
    bus.ex_funct3 = f;
    bus.ex_rs1    = a;
    bus.ex_rs2    = b;
    bus.ex_pc     = pc;
    bus.ex_imm    = imm;
    tk  = model_taken(t, f, a, b);
    sum = a + imm;
    tgt = (t == 2'b10) ? {sum[31:1], 1'b0} : pc + imm;
    if (tk) begin
      m_target = tgt;
      if (m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
    end else if (m_nc != 16'hFFFF) begin
      m_nc = m_nc + 16'd1;
    end
    m_link = pc + 32'd4;
    if (model_illegal(t, f)) m_err = 1'b1;
    e = '{pc_sel: tk, target: m_target, link: m_link, tc: m_tc, nc: m_nc, err: m_err};
    sb.push_back(e);
    step();
    bus.ex_valid = 1'b0;
    chk({tag, "_sb_avail"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_pcsel"}, {31'd0, bus.pc_sel}, {31'd0, e.pc_sel});
      chk({tag, "_flush"}, {31'd0, bus.flush}, {31'd0, e.pc_sel});
      chk({tag, "_hold_off"}, {31'd0, bus.fetch_hold}, 32'd0);
      chk({tag, "_target"}, bus.pc_target, e.target);
      chk({tag, "_link"}, bus.link_addr, e.link);
      chk({tag, "_tcnt"}, {16'd0, bus.taken_cnt}, {16'd0, e.tc});
      chk({tag, "_ncnt"}, {16'd0, bus.nottaken_cnt}, {16'd0, e.nc});
      chk({tag, "_err"}, {31'd0, bus.resolve_err}, {31'd0, e.err});
      if (e.pc_sel) begin
        step();
        chk({tag, "_redir_end"}, {31'd0, bus.pc_sel}, 32'd0);
        chk({tag, "_flush_end"}, {31'd0, bus.flush}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [15:0] sat_exp;
    int          r;
    rst = 1'b1;
    bus.br_det = 1'b0; bus.ex_valid = 1'b0; bus.ex_type = '0; bus.ex_funct3 = '0;
    bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_pc = '0; bus.ex_imm = '0;
    sat_bus.br_det = 1'b0; sat_bus.ex_valid = 1'b0; sat_bus.ex_type = 2'b01;
    sat_bus.ex_funct3 = '0; sat_bus.ex_rs1 = '0; sat_bus.ex_rs2 = '0;
    sat_bus.ex_pc = 32'h100; sat_bus.ex_imm = 32'h20;
    model_reset();
    step();
    step();
    chk("rst_hold", {31'd0, bus.fetch_hold}, 32'd0);
    chk("rst_pcsel", {31'd0, bus.pc_sel}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk_state("rst");
    rst = 1'b0;

    resolve("beq", 2'b00, 3'b000, 32'd5, 32'd5, 32'h10, 32'h8);
    chk("beq_target_abs", bus.pc_target, 32'h18);
    chk("beq_link_abs", bus.link_addr, 32'h14);
    chk("beq_tcnt_abs", {16'd0, bus.taken_cnt}, 32'd1);

    resolve("bgeu", 2'b00, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h100, 32'h40);
    chk("bgeu_ncnt_abs", {16'd0, bus.nottaken_cnt}, 32'd1);
    chk("bgeu_target_held", bus.pc_target, 32'h18);
    resolve("bge", 2'b00, 3'b101, 32'd1, 32'hFFFF_FFFF, 32'h200, 32'h20);
    chk("bge_target_abs", bus.pc_target, 32'h220);

    resolve("jalr", 2'b10, 3'b000, 32'h1001, 32'h7, 32'h300, 32'h2);
    chk("jalr_target_abs", bus.pc_target, 32'h1002);
    resolve("wrap", 2'b00, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFF8, 32'h10);
    chk("wrap_target_abs", bus.pc_target, 32'h8);
    chk("wrap_link_abs", bus.link_addr, 32'hFFFF_FFFC);
    resolve("jal", 2'b01, 3'b000, 32'd0, 32'd0, 32'h400, 32'hFFFF_FFF0);
    chk("jal_target_abs", bus.pc_target, 32'h3F0);

    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 7);
      bus.ex_rs1 = $urandom;
      resolve("rand", (r < 6) ? 2'b00 : ((r == 6) ? 2'b01 : 2'b10),
              (r < 6) ? legal_f3[r] : 3'd0, bus.ex_rs1,
              ($urandom_range(0, 1) == 0) ? bus.ex_rs1 : $urandom, $urandom, $urandom);
    end

    // Timeout: four held cycles, then IDLE with the error flag set.
    bus.br_det = 1'b1;
    step();
    bus.br_det = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_hold", {31'd0, bus.fetch_hold}, 32'd1);
      if (i < 3) step();
    end
    step();
    m_err = 1'b1;
    chk("tmo_release", {31'd0, bus.fetch_hold}, 32'd0);
    chk("tmo_pcsel", {31'd0, bus.pc_sel}, 32'd0);
    chk_state("tmo");

    do_reset();
    resolve("illegal_f3", 2'b00, 3'b010, 32'd3, 32'd3, 32'h500, 32'h8);
    chk("illegal_f3_err_abs", {31'd0, bus.resolve_err}, 32'd1);

    do_reset();
    resolve("type11", 2'b11, 3'b000, 32'd3, 32'd3, 32'h500, 32'h8);

    do_reset();
    bus.ex_valid = 1'b1; bus.ex_type = 2'b01; bus.ex_pc = 32'h600; bus.ex_imm = 32'h10;
    step();
    bus.ex_valid = 1'b0;
    m_err = 1'b1;
    chk("idle_ev_pcsel", {31'd0, bus.pc_sel}, 32'd0);
    chk_state("idle_ev");

    do_reset();
    bus.br_det = 1'b1;
    step();
    bus.br_det = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pend_hold", {31'd0, bus.fetch_hold}, 32'd0);
    chk_state("rst_pend");
    bus.ex_valid = 1'b1; bus.ex_type = 2'b01; bus.ex_pc = 32'h700; bus.ex_imm = 32'h40;
    step();
    bus.ex_valid = 1'b0;
    m_err = 1'b1;
    chk("rst_pend_ev_pcsel", {31'd0, bus.pc_sel}, 32'd0);
    chk_state("rst_pend_ev");
    step();
    chk("rst_pend_no_redir", {31'd0, bus.pc_sel}, 32'd0);

    do_reset();
    bus.br_det = 1'b1;
    step();
    bus.br_det = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_type = 2'b01; bus.ex_pc = 32'h800; bus.ex_imm = 32'h40;
    step();
    bus.ex_valid = 1'b0;
    chk("redir_pcsel", {31'd0, bus.pc_sel}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_redir_pcsel", {31'd0, bus.pc_sel}, 32'd0);
    chk("rst_redir_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_redir_target", bus.pc_target, 32'h0);

    do_reset();
    bus.br_det = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_type = 2'b01; bus.ex_pc = 32'h900; bus.ex_imm = 32'h10;
    step();
    bus.br_det = 1'b0;
    chk("both_hold", {31'd0, bus.fetch_hold}, 32'd1);
    chk("both_err", {31'd0, bus.resolve_err}, 32'd1);
    chk("both_tcnt", {16'd0, bus.taken_cnt}, 32'd0);
    bus.ex_imm = 32'h100;
    step();
    bus.ex_valid = 1'b0;
    chk("both_pcsel", {31'd0, bus.pc_sel}, 32'd1);
    chk("both_target", bus.pc_target, 32'hA00);
    chk("both_tcnt_after", {16'd0, bus.taken_cnt}, 32'd1);

    // Narrow-counter instance: saturates at 4'hF.
    do_reset();
    sat_exp = '0;
    for (int i = 0; i < 17; i++) begin
      sat_bus.br_det = 1'b1;
      step();
      sat_bus.br_det = 1'b0;
      sat_bus.ex_valid = 1'b1;
      step();
      sat_bus.ex_valid = 1'b0;
      step();
      if (sat_exp != 16'h000F) sat_exp = sat_exp + 16'd1;
      if (i >= 14) chk("sat_tcnt", {16'd0, sat_bus.taken_cnt}, {16'd0, sat_exp});
    end
    chk("sat_tcnt_max", {16'd0, sat_bus.taken_cnt}, 32'h0000_000F);
    chk("sat_ncnt", {16'd0, sat_bus.nottaken_cnt}, 32'd0);
    chk("sat_err", {31'd0, sat_bus.resolve_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter WAIT_MAX, default 4: maximum cycles in PEND without ex_valid before timeout.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 br_det  input  1  IF-stage flag: control-flow instruction detected; branch detector output.
REQ-005 ex_valid  input  1  EX-stage resolution data valid this cycle.
REQ-006 ex_type  input  2  00 conditional branch, 01 JAL, 10 JALR, 11 reserved.
REQ-007 ex_funct3  input  3  branch condition, RV32I B-type encoding.
REQ-008 ex_rs1, ex_rs2  input  32 each  source operand values.
REQ-009 ex_pc, ex_imm  input  32 each  instruction PC; sign-extended immediate.
REQ-010 fetch_hold  output  1  freeze PC/IF.
REQ-011 pc_sel  output  1  PC loads pc_target this cycle.
REQ-012 flush  output  1  squash IF/ID wrong-path instruction.
REQ-013 pc_target  output  32  redirect address.
REQ-014 link_addr  output  32  ex_pc+4 of last resolved instruction.
REQ-015 resolve_err  output  1  sticky protocol-error flag.
REQ-016 taken_cnt, nottaken_cnt  output  16 each  resolution statistics.

Function
REQ-017 FSM states SHALL be IDLE, PEND, REDIR.
REQ-018 IDLE: br_det=1 -> PEND, wait counter cleared to 0; else stay.
REQ-019 fetch_hold SHALL equal (state==PEND), combinational from state.
REQ-020 PEND, ex_valid=1: taken -> REDIR; not taken -> IDLE; pc_target/link_addr registered the same edge.
REQ-021 PEND, ex_valid=0: wait counter +1; counter reaching WAIT_MAX -> IDLE, resolve_err<=1.
REQ-022 REDIR: pc_sel=1, flush=1 for exactly one cycle, then unconditionally -> IDLE; br_det ignored in REDIR.
REQ-023 pc_sel and flush SHALL be 0 in IDLE and PEND.
REQ-024 Taken rule, ex_type 00: funct3 000 rs1==rs2; 001 !=; 100 signed <; 101 signed >=; 110 unsigned <; 111 unsigned >=.
REQ-025 funct3 010/011 or ex_type 11: treated as not taken, resolve_err<=1.
REQ-026 JAL, JALR: always taken.
REQ-027 Target: types 00/01 ex_pc+ex_imm; JALR (ex_rs1+ex_imm) with bit0 cleared; all sums modulo 2^32, no overflow flag.
REQ-028 link_addr = ex_pc+4 modulo 2^32, updated on each resolution (taken or not).
REQ-029 pc_target updated only on taken resolution; holds otherwise.
REQ-030 ex_valid=1 in IDLE or REDIR: ignored for redirect/counters; resolve_err<=1.
REQ-031 Each PEND resolution increments exactly one of taken_cnt / nottaken_cnt; saturate at 0xFFFF; timeouts not counted.
REQ-032 br_det and ex_valid both high in IDLE: enter PEND; ex_valid handled per REQ-030.
REQ-033 resolve_err cleared only by rst.

Reset
REQ-034 rst=1 at clock edge: state IDLE, wait counter 0, pc_sel 0, flush 0, fetch_hold 0, pc_target 0, link_addr 0, resolve_err 0, both counters 0.
REQ-035 rst SHALL override all other inputs, including mid-PEND and mid-REDIR; no redirect after reset.

Verification
REQ-036 BEQ taken: br_det 1 cycle; next cycle ex_valid, type 00, funct3 000, rs1=rs2=5, pc 0x10, imm 0x8 -> following cycle pc_sel=flush=1, pc_target 0x18, link_addr 0x14; then IDLE; taken_cnt=1.
REQ-037 Signedness: BGEU rs1=1, rs2=0xFFFFFFFF -> not taken, pc_sel 0, fetch_hold drops, nottaken_cnt=1; BGE same operands -> taken.
REQ-038 JALR rs1=0x1001, imm=0x2 -> pc_target 0x1002; PC wrap: branch pc 0xFFFFFFF8, imm 0x10 taken -> pc_target 0x00000008, link_addr 0xFFFFFFFC.
REQ-039 Timeout WAIT_MAX=4: br_det, no ex_valid -> fetch_hold high 4 cycles, then resolve_err=1, IDLE, counters unchanged.
REQ-040 Reset mid-PEND: br_det, then rst -> next cycle fetch_hold 0, all outputs 0; later ex_valid ignored except resolve_err=1.
REQ-041 Saturation: preload via 65535 taken resolutions, one more -> taken_cnt stays 0xFFFF.
